spi_word_receiver: RTL and testbench
====================================

// Module: spi_word_receiver
// PURPOSE
//  SPI slave front end, mode 0 (CPOL=0, CPHA=0), MSB first. Oversamples external SCLK/CS_n/MOSI in the clk domain.
//  Assembles WORD_W-bit words and publishes a running bit index plus the completed word.
//  Sits directly upstream of the memory buffering stage:
//   - spi_count drives that stage's capture condition (==15) and re-arm condition (==0).
//   - spi_word drives that stage's data input.
// PARAMETERS
//  WORD_W       16  bits per word; must be <= 2**CNT_W
//  CNT_W        8   width of spi_count
//  SYNC_STAGES  2   flops in each input synchronizer (>=2)
// PORTS
//  clk         in   1        system clock; all logic on posedge
//  reset       in   1        synchronous, active-high reset
//  spi_sclk    in   1        async SPI clock from master
//  spi_cs_n    in   1        async chip select, active low
//  spi_mosi    in   1        async serial data, sampled on SCLK rise
//  spi_count   out  CNT_W    index of last received bit in current word (0..WORD_W-1)
//  spi_word    out  WORD_W   last completed word, MSB = first bit received
//  word_valid  out  1        1-cycle pulse when spi_word updates
//  busy        out  1        high while CS active (synced)
//  frame_err   out  1        1-cycle pulse on aborted word (SPI_FRAME_ERR_EN only)
// BEHAVIOUR
//  - Reset: spi_count=0, spi_word=0, word_valid=0, busy=0, frame_err=0, shift reg=0, FSM=IDLE. Reset wins over any SPI event the same cycle.
//  - Synchronizers: sclk, cs_n and mosi each pass SYNC_STAGES flops. Edges are detected on the synced sclk/cs_n vs. a one-cycle-delayed copy.
//  - Timing requirement: SCLK high and low phases each >= SYNC_STAGES+2 clk periods (clk >= 8x SCLK with defaults).
//  - Latency: pin SCLK rise -> spi_count/spi_word update = SYNC_STAGES+1 clk cycles.
//  - FSM states:
//   - IDLE: synced cs_n=1; busy=0. On cs_n fall -> SHIFT with bit_cnt=0.
//   - SHIFT: each synced sclk rise shifts mosi in at the LSB; bit_cnt++; spi_count=bit_cnt-1 (post-increment).
//     - On the WORD_W-th bit: spi_word<=shift reg incl. new bit; word_valid=1 for one cycle; bit_cnt<=0; stay in SHIFT for back-to-back words.
//   - Any state, cs_n rise -> IDLE: bit_cnt<=0; spi_count<=0 on the next cycle.
//  - spi_count holds its value between SCLK edges:
//   - After the last bit it stays WORD_W-1 until the first bit of the next word (->0) or CS deassert (->0).
//   - Downstream therefore sees exactly one 15->0 transition per word.
//  - SCLK edges while cs_n synced high are ignored. An SCLK rise in the same cycle as cs_n fall is ignored.
//  - Partial word at cs_n rise: discarded; spi_word unchanged; word_valid stays 0.
//  - spi_word changes only together with word_valid.
//  - bit_cnt width = $clog2(WORD_W+1); spi_count zero-extended to CNT_W.
// CONFIGURATION
//  SPI_FRAME_ERR_EN defined:
//   - frame_err pulses 1 cycle when cs_n rises with 0 < bit_cnt < WORD_W.
//   - A sticky err_seen flop is kept, cleared only by reset.
//  SPI_FRAME_ERR_EN undefined: frame_err port tied 0, no error logic synthesized; partial words still discarded.
// STRUCTURE
//  - Package spi_rx_pkg: localparams SPI_WORD_W=16, SPI_CNT_W=8; typedef enum logic [1:0] {RX_IDLE, RX_SHIFT} rx_state_t.
//  - Sub-module sync_edge_detect (#SYNC_STAGES): synchronizer plus rise/fall pulses.
//   - Instanced for sclk and cs_n.
//   - mosi uses a plain synchronizer of equal depth to stay aligned.
// TESTING (clk 50 MHz, SCLK 2 MHz, SYNC_STAGES=2)
//  - Send 0xA5C3 in one CS frame -> one word_valid pulse, spi_word=16'hA5C3, spi_count 0..15 then held at 15, ->0 after CS rise.
//  - Two back-to-back words 0x1234, 0xFFFF without CS release -> two word_valid pulses, spi_word 0x1234 then 0xFFFF, spi_count 15->0 exactly twice.
//  - CS low, 7 bits, CS high -> no word_valid, spi_word unchanged, spi_count 0. With SPI_FRAME_ERR_EN: frame_err one pulse; without: frame_err stays 0.
//  - Toggle SCLK 20 times with CS high, MOSI random -> no word_valid, spi_count 0, busy 0.
//  - Assert reset after 9 bits of 0x0F0F -> all outputs at reset values next cycle; new CS frame 0x8001 received correctly.
//  - Measure pin SCLK rise (16th bit) -> word_valid: exactly 3 clk cycles.

Source files
------------

// File: rtl/spi_rx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_rx_pkg : shared widths and FSM encoding for the SPI word receiver       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package spi_rx_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_CNT_W  = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_word_receiver_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_word_receiver_if : SPI pins plus the word/count bus seen by downstream  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface spi_word_receiver_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
);
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic [CNT_W-1:0]  spi_count;
    logic [WORD_W-1:0] spi_word;
    logic              word_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_count, spi_word, word_valid, busy, frame_err
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_count, spi_word, word_valid, busy, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sync_edge_detect : multi-flop synchronizer with rise/fall pulses            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] &  prev_q;
endmodule
`default_nettype wire

// File: rtl/spi_word_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_word_receiver : SPI mode-0 slave, MSB first, oversampled in clk domain  |
// | Optional abort reporting: define SPI_FRAME_ERR_EN                           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module spi_word_receiver
    import spi_rx_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W,
    parameter int CNT_W       = SPI_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input wire              clk,
    input wire              reset,
    spi_word_receiver_if.slave bus
);
    localparam int              BCW      = $clog2(WORD_W + 1);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WORD_W - 1);
    localparam logic [BCW-1:0]  BIT_ONE  = BCW'(1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic sync_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(bus.spi_sclk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs_n idles high, so its chain resets high to avoid a false fall edge
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .d(bus.spi_cs_n),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign sync_unused = sclk_s ^ sclk_fall ^ cs_s;

    // Same depth as the edge detectors so data lines up with the sclk rise pulse
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};

    always_ff @(posedge clk) begin
        if (reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= mosi_sync_d;
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    rx_state_t         state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  spi_count_q, spi_count_d;
    logic [WORD_W-1:0] spi_word_q, spi_word_d;
    logic              word_valid_q, word_valid_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        spi_count_d  = spi_count_q;
        spi_word_d   = spi_word_q;
        word_valid_d = 1'b0;

        if (cs_rise) begin
            state_d     = RX_IDLE;
            bit_cnt_d   = '0;
            spi_count_d = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (cs_fall) begin
                        state_d   = RX_SHIFT;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                RX_SHIFT: begin
                    if (sclk_rise) begin
                        shift_d     = {shift_q[WORD_W-2:0], mosi_s};
                        spi_count_d = CNT_W'(bit_cnt_q);
                        if (bit_cnt_q == LAST_BIT) begin
                            spi_word_d   = shift_d;
                            word_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            spi_count_q  <= '0;
            spi_word_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            spi_count_q  <= spi_count_d;
            spi_word_q   <= spi_word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bus.spi_count  = spi_count_q;
    assign bus.spi_word   = spi_word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.busy       = (state_q == RX_SHIFT);

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;
    logic err_seen_q, err_seen_d;
    logic err_unused;

    always_comb begin
        frame_err_d = cs_rise && (state_q == RX_SHIFT) && (bit_cnt_q != '0);
        err_seen_d  = err_seen_q | frame_err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            err_seen_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign err_unused    = err_seen_q;
    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_word_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_spi_word_receiver : table-driven frames with a word scoreboard           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_spi_word_receiver;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    spi_word_receiver_if #(.WORD_W(16), .CNT_W(8)) bus ();

    spi_word_receiver #(.WORD_W(16), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

`ifdef SPI_FRAME_ERR_EN
    localparam int FERR_EXP = 1;
`else
    localparam int FERR_EXP = 0;
`endif

    typedef struct {
        logic [31:0] data;
        int          nbits;
        int          exp_valid;
        int          exp_wraps;
        int          exp_ferr;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          valid_cnt = 0;
    int          wrap_cnt  = 0;
    int          ferr_cnt  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0;
    logic        rst_edge = 1'b1;
    logic [15:0] prev_word = 16'h0;
    logic [7:0]  prev_count = 8'h0;
    bit          measure_lat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_edge <= reset;

    // Scoreboard and per-cycle observers
    always @(negedge clk) begin
        if (!rst_edge) begin
            if (bus.word_valid === 1'b1) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("sb_unexpected_word", bus.spi_word, 32'hFFFF_FFFF);
                else                   check("sb_word", bus.spi_word, exp_q.pop_front());
            end else if (bus.spi_word !== prev_word) begin
                check("word_change_without_valid", bus.spi_word, prev_word);
            end
            if (prev_count == 8'd15 && bus.spi_count == 8'd0) wrap_cnt++;
            if (bus.frame_err === 1'b1) ferr_cnt++;
        end
        prev_word  = bus.spi_word;
        prev_count = bus.spi_count;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        logic [15:0] acc;
        logic        b;
        int          lat;
        acc = 16'h0;
        for (int i = 0; i < n; i++) begin
            b   = data[31-i];
            acc = {acc[14:0], b};
            if (i % 16 == 15) begin
                exp_q.push_back(acc);
                last_exp = acc;
            end
            bus.spi_sclk = 1'b0;
            bus.spi_mosi = b;
            step(12);
            bus.spi_sclk = 1'b1;
            lat = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                if (measure_lat && i == 15 && lat == 0 && bus.word_valid === 1'b1) lat = c + 1;
            end
            #1;
            check("bit_count", bus.spi_count, i % 16);
            if (i == 0) check("busy_in_frame", bus.busy, 1);
            if (measure_lat && i == 15) begin
                check("sclk_to_valid_latency", lat, 3);
                measure_lat = 1'b0;
            end
        end
        bus.spi_sclk = 1'b0;
        step(12);
    endtask

    task automatic run_frame(input vec_t v);
        int v0, w0, f0;
        v0 = valid_cnt;
        w0 = wrap_cnt;
        f0 = ferr_cnt;
        bus.spi_cs_n = 1'b0;
        step(8);
        send_bits(v.data, v.nbits);
        bus.spi_cs_n = 1'b1;
        step(10);
        check("frame_valid_pulses", valid_cnt - v0, v.exp_valid);
        check("frame_count_wraps",  wrap_cnt - w0,  v.exp_wraps);
        check("frame_err_pulses",   ferr_cnt - f0,  v.exp_ferr);
        check("count_after_cs",     bus.spi_count, 0);
        check("busy_after_cs",      bus.busy, 0);
        check("word_after_cs",      bus.spi_word, last_exp);
    endtask

    vec_t tbl[4];

    initial begin
        int v0;
        tbl[0] = '{32'hA5C3_0000, 16, 1, 1, 0};
        tbl[1] = '{32'h1234_FFFF, 32, 2, 2, 0};
        tbl[2] = '{32'hB400_0000,  7, 0, 0, FERR_EXP};
        tbl[3] = '{32'h00FF_0000, 16, 1, 1, 0};

        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        step(3);
        check("reset_count", bus.spi_count, 0);
        check("reset_word",  bus.spi_word, 0);
        check("reset_valid", bus.word_valid, 0);
        check("reset_busy",  bus.busy, 0);
        check("reset_ferr",  bus.frame_err, 0);
        reset = 1'b0;
        step(5);

        measure_lat = 1'b1;
        for (int k = 0; k < 4; k++) run_frame(tbl[k]);

        // SCLK activity with CS deasserted must be ignored
        v0 = valid_cnt;
        for (int k = 0; k < 20; k++) begin
            bus.spi_mosi = 1'($urandom);
            bus.spi_sclk = 1'b1;
            step(6);
            bus.spi_sclk = 1'b0;
            step(6);
        end
        check("idle_sclk_valid", valid_cnt - v0, 0);
        check("idle_sclk_count", bus.spi_count, 0);
        check("idle_sclk_busy",  bus.busy, 0);

        // Reset in the middle of a word, then a clean frame
        bus.spi_cs_n = 1'b0;
        step(8);
        send_bits(32'h0F0F_0000, 9);
        reset        = 1'b1;
        bus.spi_cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_count", bus.spi_count, 0);
        check("midreset_word",  bus.spi_word, 0);
        check("midreset_valid", bus.word_valid, 0);
        check("midreset_busy",  bus.busy, 0);
        check("midreset_ferr",  bus.frame_err, 0);
        last_exp = 16'h0;
        step(1);
        reset = 1'b0;
        step(10);
        run_frame('{32'h8001_0000, 16, 1, 1, 0});

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
